// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants.
// Holds the fetch FSM encoding, the instruction width and the PC increment.
package mips_pkg;
    localparam int          INSTR_W   = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int          PC_STEP   = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } fetch_state_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer that parks a fetched word while decode stalls.
// Priority is clear, then load, then pop. The output is registered, so the buffer adds one cycle.
module fetch_skid_buf
    import mips_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               pop,
    input  logic               clear,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [AW-1:0]      load_pc,
    input  logic               load_misaligned,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [AW-1:0]      pc,
    output logic               misaligned
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid      <= 1'b0;
            instr      <= NOP_INSTR;
            pc         <= '0;
            misaligned <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid      <= 1'b1;
            instr      <= load_instr;
            pc         <= load_pc;
            misaligned <= load_misaligned;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: one outstanding imem request, PC advance on grant, and an IF/ID register backed by a skid entry.
// A flush kills the IF/ID contents and any in-flight response.
module instr_fetch
    import mips_pkg::*;
#(
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [AW-1:0]      pc_in,
    output logic               pc_en,
    output logic               imem_req,
    output logic [AW-1:0]      imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               flush,
    input  logic               id_ready,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [AW-1:0]      if_pc,
    output logic [AW-1:0]      if_pc_plus4,
    output logic               if_misaligned
);

    fetch_state_t       state;
    logic               drop;
    logic [AW-1:0]      req_pc;
    logic               req_mis;

    logic               rsp_take, rsp_direct, skid_load, skid_pop;
    logic               skid_valid, skid_mis;
    logic [INSTR_W-1:0] skid_instr;
    logic [AW-1:0]      skid_pc;
    logic               ld_en, ld_mis;
    logic [INSTR_W-1:0] ld_instr;
    logic [AW-1:0]      ld_pc;

    assign imem_req  = (state == REQ) && !flush;
    assign pc_en     = imem_req && imem_gnt;
    assign imem_addr = (state == REQ) ? {pc_in[AW-1:2], 2'b00} : '0;

    // A response is kept only if no flush is pending against it or arriving with it.
    assign rsp_take   = (state == WAIT) && imem_rvalid && !flush && !drop;
    assign rsp_direct = rsp_take && (!if_valid || id_ready);
    assign skid_load  = rsp_take && !rsp_direct;
    assign skid_pop   = (state == HOLD) && !flush && id_ready && skid_valid;

    always_comb begin
        ld_en    = rsp_direct || skid_pop;
        ld_instr = imem_rdata;
        ld_pc    = req_pc;
        ld_mis   = req_mis;
        if (skid_pop) begin
            ld_instr = skid_instr;
            ld_pc    = skid_pc;
            ld_mis   = skid_mis;
        end
    end

    fetch_skid_buf #(.AW(AW)) u_skid (
        .clk             (clk),
        .reset           (reset),
        .load            (skid_load),
        .pop             (skid_pop),
        .clear           (flush),
        .load_instr      (imem_rdata),
        .load_pc         (req_pc),
        .load_misaligned (req_mis),
        .valid           (skid_valid),
        .instr           (skid_instr),
        .pc              (skid_pc),
        .misaligned      (skid_mis)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            drop    <= 1'b0;
            req_pc  <= '0;
            req_mis <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (pc_en) begin
                        req_pc  <= pc_in;
                        req_mis <= |pc_in[1:0];
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        drop  <= 1'b0;
                        state <= skid_load ? HOLD : REQ;
                    end else if (flush) begin
                        drop <= 1'b1;
                    end
                end
                HOLD: begin
                    if (flush || skid_pop) state <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_valid      <= 1'b0;
            if_instr      <= NOP_INSTR;
            if_pc         <= RESET_PC;
            if_pc_plus4   <= RESET_PC + AW'(PC_STEP);
            if_misaligned <= 1'b0;
        end else if (ld_en) begin
            if_valid      <= 1'b1;
            if_instr      <= ld_instr;
            if_pc         <= ld_pc;
            if_pc_plus4   <= ld_pc + AW'(PC_STEP);
            if_misaligned <= ld_mis;
        end else if (flush || (if_valid && id_ready)) begin
            if_valid <= 1'b0;
        end
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly downstream of the program-counter register.
- Takes the current PC and issues one instruction-memory request at a time using a req/gnt/rvalid handshake.
- Tells the PC register when to advance, and holds the IF/ID pipeline register with a one-entry skid buffer so decode stalls and branch flushes never lose or duplicate an instruction.

Parameters:
- AW, 32, PC/address width in bits (must be >= 3).
- RESET_PC, 0, value reported on if_pc while empty after reset (debug only).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- pc_in  input  AW  current PC register value.
- pc_en  output  1  one-cycle pulse: PC register loads its next value.
- imem_req  output  1  instruction-memory request valid.
- imem_addr  output  AW  request address, word aligned.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  read data valid; arrives >=1 cycle after gnt.
- imem_rdata  input  32  instruction word.
- flush  input  1  branch/jump redirect; PC loads target this cycle externally.
- id_ready  input  1  decode accepts if_* this cycle.
- if_valid  output  1  IF/ID register holds a valid instruction.
- if_instr  output  32  instruction.
- if_pc  output  AW  address of if_instr.
- if_pc_plus4  output  AW  if_pc + 4, modulo 2^AW.
- if_misaligned  output  1  pc_in[1:0] was nonzero at request.

Behaviour:
Reset values (reset low, asynchronous):
- state=IDLE; all outputs 0 except if_pc=RESET_PC and if_pc_plus4=RESET_PC+4.
- Skid buffer empty; drop flag clear.

States:
- IDLE: one cycle after reset release, then REQ.
- REQ: imem_req=1 and imem_addr={pc_in[AW-1:2],2'b00}, both combinational from pc_in.
  - On imem_gnt: pc_en=1 the same cycle; latch pc_in and its misalign bit into req_pc; go to WAIT.
  - Without gnt: hold request; addr follows pc_in.
- WAIT: imem_req=0. On imem_rvalid:
  - Output slot empty, or id_ready=1 this cycle: load if_* from rdata/req_pc; go to REQ.
  - Otherwise: write the skid buffer; go to HOLD.
- HOLD: imem_req=0. On id_ready: move skid into if_*; go to REQ.

Handshake and timing:
- if_* is consumed on if_valid & id_ready.
- if_valid clears on consume unless a new word loads in the same cycle.
- Best-case throughput: one instruction per 2 cycles with 1-cycle memory latency.
- Exactly one outstanding request; pc_en never pulses without a gnt.

Flush (highest priority):
- if_valid is cleared next cycle.
- Skid buffer is emptied.
- In REQ: imem_req is forced 0 and pc_en=0 that cycle (a gnt is impossible).
- In WAIT: set the drop flag. The pending rvalid is discarded, then go to REQ; drop clears on that rvalid.
- flush coinciding with rvalid in WAIT: the word is discarded and the drop flag is not set.
- In HOLD: go to REQ.
- Flush repeated during drop: no extra effect.

Boundary conditions:
- pc_in = 2^AW-4 gives if_pc_plus4 = 0.
- id_ready with if_valid=0 is ignored.
- Reset mid-WAIT: a late rvalid after reset release, before the first gnt, is ignored (state ≠ WAIT).

Decomposition:
- Shared package mips_pkg:
  - fetch state enum (IDLE, REQ, WAIT, HOLD).
  - INSTR_W=32.
  - NOP_INSTR=32'h0000_0000.
  - PC_STEP=4.
- One natural sub-module: fetch_skid_buf, holding the 1-entry buffer {instr, pc, misaligned, valid} with load/pop/clear.
- The FSM and IF/ID register stay in instr_fetch.

Test Plan:
- Reset release, pc_in=0x0, gnt immediate, rvalid 1 cycle later with rdata=0x2008_0005, id_ready=1 → imem_addr=0x0, pc_en pulses once, if_valid=1, if_instr=0x2008_0005, if_pc=0x0, if_pc_plus4=0x4.
- Decode stall: id_ready=0 with if_valid holding 0x4, second word 0xAAAA_0001 at pc 0x8 arrives → state HOLD, no new imem_req. Raising id_ready shows 0x4 consumed, then 0x8/0xAAAA_0001 presented, then imem_req reasserts.
- Flush in WAIT: gnt at 0x10, flush next cycle, rvalid two cycles later with 0xDEAD_BEEF → word dropped, if_valid=0, next request at redirect target 0x40.
- gnt withheld 3 cycles → imem_req held high, pc_en=0 until the gnt cycle, then exactly one pulse.
- Misalignment and wrap: pc_in=0xFFFF_FFFE → imem_addr=0xFFFF_FFFC, if_misaligned=1, if_pc_plus4=0x0000_0002.
- Async reset asserted mid-WAIT then released → outputs reset immediately; a stray rvalid is ignored; the first request follows IDLE.
